// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcode class anchors, FSM state
// and opcode class enums used by the stage and the decoder hazard logic.
package mem_stage_pkg;

  localparam logic [9:0] OPC_LOAD      = 10'h040;
  localparam logic [9:0] OPC_STORE     = 10'h048;
  localparam logic [9:0] OPC_PUSH_BASE = 10'h050;
  localparam logic [9:0] OPC_POP_BASE  = 10'h058;
  localparam logic [9:0] OPC_CALL      = 10'h0E8;
  localparam logic [9:0] OPC_CALL_IND  = 10'h310;
  localparam logic [9:0] OPC_RET       = 10'h0C3;
  localparam logic [9:0] OPC_SYSCALL   = 10'h105;
  localparam logic [9:0] OPC_JMP       = 10'h0E9;
  localparam logic [9:0] OPC_JCC_BASE  = 10'h180;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  typedef enum logic [1:0] {
    CL_ALU,
    CL_NOWB,
    CL_LOAD,
    CL_STORE
  } mem_class_t;

  function automatic logic is_mem_class(mem_class_t cls);
    return (cls == CL_LOAD) || (cls == CL_STORE);
  endfunction

endpackage

// File: rtl/mem_op_classify.sv
// Combinational opcode -> memory class decode; also used by the decoder
// for hazard detection, so it must stay free of state.
module mem_op_classify
  import mem_stage_pkg::*;
(
  input  logic [9:0] opcode,
  output mem_class_t mem_class
);

  logic is_load;
  logic is_store;
  logic is_nowb;

  // PUSH/POP occupy 8-entry blocks, Jcc a 16-entry block.
  assign is_load  = (opcode == OPC_LOAD) ||
                    (opcode[9:3] == OPC_POP_BASE[9:3]);
  assign is_store = (opcode == OPC_STORE) ||
                    (opcode[9:3] == OPC_PUSH_BASE[9:3]) ||
                    (opcode == OPC_CALL) ||
                    (opcode == OPC_CALL_IND);
  assign is_nowb  = (opcode == OPC_RET) ||
                    (opcode == OPC_SYSCALL) ||
                    (opcode == OPC_JMP) ||
                    (opcode[9:4] == OPC_JCC_BASE[9:4]);

  always_comb begin
    mem_class = CL_ALU;
    if (is_load) begin
      mem_class = CL_LOAD;
    end else if (is_store) begin
      mem_class = CL_STORE;
    end else if (is_nowb) begin
      mem_class = CL_NOWB;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: accepts ALU results, issues one load/store at a time over a
// valid/ready request channel and emits one registered writeback per op.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         exe_mem,
  input  logic [9:0]   opcode,
  input  logic [127:0] result,
  input  logic [63:0]  rflags,
  input  logic [63:0]  store_data,
  input  logic [3:0]   dest_reg,
  output logic         mem_blocked,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_write,
  output logic [63:0]  mem_req_addr,
  output logic [63:0]  mem_req_wdata,
  input  logic         mem_resp_valid,
  input  logic [63:0]  mem_resp_data,
  output logic         wb_valid,
  output logic         wb_write_en,
  output logic [3:0]   wb_reg,
  output logic [63:0]  wb_data,
  output logic [63:0]  wb_rflags,
  output logic         mem_err
);

  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  mem_state_t  state_q, state_d;
  mem_class_t  in_class;
  logic [15:0] cnt_q;
  logic [63:0] cap_addr_q;
  logic [63:0] cap_wdata_q;
  logic [63:0] cap_rflags_q;
  logic [3:0]  cap_reg_q;
  logic        cap_write_q;
  logic        accept;
  logic        req_fire;
  logic        resp_done;
  logic        timed_out;
  logic        wait_hit;
  logic        unused_result_hi;

  assign unused_result_hi = ^result[127:64];

  mem_op_classify u_classify (
    .opcode    (opcode),
    .mem_class (in_class)
  );

  // Counter value after this WAIT cycle reaches TIMEOUT.
  assign wait_hit = (({1'b0, cnt_q} + 17'd1) == TIMEOUT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_fire  = 1'b0;
    resp_done = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (exe_mem) begin
          accept = 1'b1;
          if (is_mem_class(in_class)) begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          req_fire = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // A response in the terminal cycle takes priority over the timeout.
        if (mem_resp_valid) begin
          resp_done = 1'b1;
          state_d   = IDLE;
        end else if (wait_hit) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_blocked   = (state_q != IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_write = cap_write_q;
  assign mem_req_addr  = cap_addr_q;
  assign mem_req_wdata = cap_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      cap_rflags_q <= '0;
      cap_reg_q    <= '0;
      cap_write_q  <= 1'b0;
    end else if (accept) begin
      cap_addr_q   <= result[63:0];
      cap_wdata_q  <= store_data;
      cap_rflags_q <= rflags;
      cap_reg_q    <= dest_reg;
      cap_write_q  <= (in_class == CL_STORE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (req_fire) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_write_en <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      wb_rflags   <= '0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_write_en <= 1'b0;
      mem_err     <= 1'b0;
      if (accept && !is_mem_class(in_class)) begin
        wb_valid    <= 1'b1;
        wb_write_en <= (in_class == CL_ALU);
        wb_reg      <= dest_reg;
        wb_data     <= result[63:0];
        wb_rflags   <= rflags;
      end else if (resp_done) begin
        wb_valid    <= 1'b1;
        wb_write_en <= !cap_write_q;
        wb_reg      <= cap_reg_q;
        wb_data     <= cap_write_q ? cap_addr_q : mem_resp_data;
        wb_rflags   <= cap_rflags_q;
      end else if (timed_out) begin
        // Abandoned access still retires so the pipeline does not lose the op.
        wb_valid    <= 1'b1;
        mem_err     <= 1'b1;
        wb_reg      <= cap_reg_q;
        wb_data     <= cap_addr_q;
        wb_rflags   <= cap_rflags_q;
      end
    end
  end

endmodule
